// File: rtl/tick_scheduler.sv
// Time-multiplexed countdown timers sharing one base tick
// and one decrementer, serviced one channel per clock.
module tick_scheduler #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_cmd,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              clr_overrun,
  output logic [NUM_CH-1:0] expire,
  output logic [NUM_CH-1:0] active,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, state_d;
  logic [CH_W-1:0]   idx;
  logic              pending;
  logic [CNT_W-1:0]  per [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic              accept;
  logic              last;

  assign accept = cfg_valid && cfg_ready;
  assign last   = (idx == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (tick || pending) state_d = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      expire  <= '0;
      active  <= '0;
      mode    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        per[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      expire <= '0;
      if (clr_overrun) overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && (32'(cfg_ch) < NUM_CH)) begin
            unique case (cfg_cmd)
              2'b01, 2'b10: begin
                if (cfg_period != '0) begin
                  per[cfg_ch]    <= cfg_period;
                  cnt[cfg_ch]    <= cfg_period;
                  mode[cfg_ch]   <= cfg_cmd[1];
                  active[cfg_ch] <= 1'b1;
                end else begin
                  active[cfg_ch] <= 1'b0;
                  cnt[cfg_ch]    <= '0;
                end
              end
              2'b00: begin
                active[cfg_ch] <= 1'b0;
                cnt[cfg_ch]    <= '0;
              end
              default: ;
            endcase
          end
          if (tick || pending) begin
            idx     <= '0;
            pending <= 1'b0;
          end
        end
        SCAN: begin
          if (active[idx]) begin
            if (cnt[idx] == CNT_W'(1)) begin
              expire[idx] <= 1'b1;
              if (mode[idx]) begin
                cnt[idx] <= per[idx];
              end else begin
                active[idx] <= 1'b0;
                cnt[idx]    <= '0;
              end
            end else begin
              cnt[idx] <= cnt[idx] - CNT_W'(1);
            end
          end
          idx <= last ? '0 : idx + CH_W'(1);
          // a second early tick has nowhere to go
          if (tick) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
